truth_table_sweeper: RTL and testbench

Self-checking exhaustive truth-table sweeper for single-output combinational functions of up to N_IN inputs. On `start` it drives every input vector 0 … 2^N_IN−1 onto the device under test and waits a programmable settle time. It samples the DUT output and compares it against a parameterised expected truth table. It then reports pass/fail, the mismatch count and the first failing vector. It sits beside the lab's combinational exercise modules on the board or in simulation and replaces manual per-table stimulus sequencing and visual result inspection.

---
 rtl/truth_table_sweeper_pkg.sv | 14 +
 rtl/truth_table_sweeper_if.sv | 34 +++
 rtl/truth_table_sweeper_settle_timer.sv | 35 +++
 rtl/truth_table_sweeper.sv | 127 ++++++++++++
 tb/tb_truth_table_sweeper.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/truth_table_sweeper_pkg.sv
// Shared types and constants for the exhaustive truth-table sweeper.
package tt_sweep_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_CHECK  = 2'd2,
    ST_DONE   = 2'd3
  } tt_state_t;

  localparam int MAX_N_IN = 8;
  localparam int SETTLE_W = 4;

endpackage

// File: rtl/truth_table_sweeper_if.sv
// Control/result bundle between the sweeper (master) and whoever starts it and
// supplies the DUT output (slave).
interface truth_table_sweeper_if
  import tt_sweep_pkg::*;
#(
  parameter int N_IN = 4
);
  // Handshake: start is a level request sampled only while idle; stop_on_fail
  // is captured at the same edge; done is a one-cycle completion pulse and the
  // result fields stay stable from done until the next accepted start.
  logic            start;
  logic            stop_on_fail;
  logic            y_dut;
  logic [N_IN-1:0] vec_out;
  logic            busy;
  logic            done;
  logic            pass;
  logic [N_IN:0]   err_count;
  logic [N_IN-1:0] first_fail;
  logic            first_fail_valid;
  tt_state_t       state_dbg;

  modport master (
    input  start, stop_on_fail, y_dut,
    output vec_out, busy, done, pass, err_count, first_fail, first_fail_valid,
           state_dbg
  );

  modport slave (
    output start, stop_on_fail, y_dut,
    input  vec_out, busy, done, pass, err_count, first_fail, first_fail_valid,
           state_dbg
  );
endinterface

// File: rtl/truth_table_sweeper_settle_timer.sv
// Loadable saturating down-counter; expired is high once the count reaches zero.
module settle_timer
  import tt_sweep_pkg::*;
#(
  parameter int SETTLE = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  output logic expired
);

  // Loading SETTLE-1 makes expired rise on the SETTLE-th cycle after load.
  localparam logic [SETTLE_W-1:0] LOAD_VAL =
    (SETTLE > 0) ? SETTLE_W'(SETTLE - 1) : '0;

  logic [SETTLE_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = LOAD_VAL;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - SETTLE_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign expired = (cnt_q == '0);

endmodule

// File: rtl/truth_table_sweeper.sv
// Walks every input vector, holds it for SETTLE cycles, checks y_dut against the
// EXPECTED table and records mismatch count and the first failing vector.
module truth_table_sweeper
  import tt_sweep_pkg::*;
#(
  parameter int                    N_IN     = 4,
  parameter logic [(1<<N_IN)-1:0]  EXPECTED = '0,
  parameter int                    SETTLE   = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  truth_table_sweeper_if.master  bus
);

  localparam logic [N_IN-1:0] VEC_LAST = '1;
  localparam logic [N_IN-1:0] VEC_ONE  = N_IN'(1);
  localparam logic [N_IN:0]   ERR_ONE  = (N_IN + 1)'(1);

  tt_state_t       state_q, state_d;
  logic [N_IN-1:0] vec_q, vec_d;
  logic [N_IN:0]   err_q, err_d;
  logic [N_IN-1:0] ff_q, ff_d;
  logic            ffv_q, ffv_d;
  logic            pass_q, pass_d;
  logic            sof_q, sof_d;
  logic            timer_load;
  logic            timer_expired;
  logic            mismatch;

  settle_timer #(.SETTLE(SETTLE)) u_settle_timer (
    .clk     (clk),
    .reset   (reset),
    .load    (timer_load),
    .expired (timer_expired)
  );

  always_comb begin
    state_d    = state_q;
    vec_d      = vec_q;
    err_d      = err_q;
    ff_d       = ff_q;
    ffv_d      = ffv_q;
    pass_d     = pass_q;
    sof_d      = sof_q;
    timer_load = 1'b0;
    mismatch   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          vec_d  = '0;
          err_d  = '0;
          ff_d   = '0;
          ffv_d  = 1'b0;
          pass_d = 1'b0;
          sof_d  = bus.stop_on_fail;
          if (SETTLE > 0) begin
            state_d    = ST_SETTLE;
            timer_load = 1'b1;
          end else begin
            state_d = ST_CHECK;
          end
        end
      end
      ST_SETTLE: begin
        if (timer_expired) state_d = ST_CHECK;
      end
      ST_CHECK: begin
        mismatch = (bus.y_dut != EXPECTED[vec_q]);
        if (mismatch) begin
          err_d = err_q + ERR_ONE;
          if (!ffv_q) begin
            ff_d  = vec_q;
            ffv_d = 1'b1;
          end
        end
        // Terminal compare on the last vector so vec_out never wraps.
        if ((vec_q == VEC_LAST) || (sof_q && mismatch)) begin
          state_d = ST_DONE;
          pass_d  = (err_d == '0);
        end else begin
          vec_d = vec_q + VEC_ONE;
          if (SETTLE > 0) begin
            state_d    = ST_SETTLE;
            timer_load = 1'b1;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      vec_q   <= '0;
      err_q   <= '0;
      ff_q    <= '0;
      ffv_q   <= 1'b0;
      pass_q  <= 1'b0;
      sof_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      err_q   <= err_d;
      ff_q    <= ff_d;
      ffv_q   <= ffv_d;
      pass_q  <= pass_d;
      sof_q   <= sof_d;
    end
  end

  assign bus.vec_out          = vec_q;
  assign bus.busy             = (state_q == ST_SETTLE) || (state_q == ST_CHECK);
  assign bus.done             = (state_q == ST_DONE);
  assign bus.pass             = pass_q;
  assign bus.err_count        = err_q;
  assign bus.first_fail       = ff_q;
  assign bus.first_fail_valid = ffv_q;
  assign bus.state_dbg        = state_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Bench for truth_table_sweeper: an 3-input/SETTLE=1 instance and a 4-input/SETTLE=0 instance.
module tb_truth_table_sweeper;
  import tt_sweep_pkg::*;

  localparam logic [7:0]  TT_A   = 8'h96;
  localparam int          SET_A  = 1;
  localparam logic [15:0] TT_B   = 16'h0000;
  localparam int          BUDGET = 200;

  // Scoreboard entry: {cycles[7:0], pass, err[4:0], first_fail[3:0], ffv}
  localparam int W = 19;

  logic clk;
  logic reset;
  int   checks;
  int   failures;
  int   mode_a;
  logic [W-1:0] exp_q[$];

  truth_table_sweeper_if #(.N_IN(3)) bus_a ();
  truth_table_sweeper_if #(.N_IN(4)) bus_b ();

  truth_table_sweeper #(.N_IN(3), .EXPECTED(TT_A), .SETTLE(SET_A)) dut_a (
    .clk(clk), .reset(reset), .bus(bus_a.master)
  );
  truth_table_sweeper #(.N_IN(4), .EXPECTED(TT_B), .SETTLE(0)) dut_b (
    .clk(clk), .reset(reset), .bus(bus_b.master)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Combinational "exercise circuit" seen by instance A.
  function automatic logic y_model(input int mode, input logic [2:0] v);
    logic y;
    y = ^v;
    if (mode == 1 && (v == 3'd5 || v == 3'd6)) y = ~y;
    if (mode == 2) y = 1'b0;
    return y;
  endfunction

  always_comb bus_a.y_dut = y_model(mode_a, bus_a.vec_out);

  // Reference model of a sweep on instance A, derived from the intended behaviour.
  function automatic logic [W-1:0] model_a(input logic stop, input int mode);
    int cyc, err, ff;
    logic ffv, mis;
    cyc = 0; err = 0; ff = 0; ffv = 1'b0;
    for (int v = 0; v < 8; v++) begin
      cyc += SET_A + 1;
      mis = (y_model(mode, 3'(v)) != TT_A[v]);
      if (mis) begin
        err++;
        if (!ffv) begin ff = v; ffv = 1'b1; end
      end
      if (stop && mis) break;
    end
    cyc += 1;
    return {8'(cyc), (err == 0), 5'(err), 4'(ff), ffv};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic run_a(input logic stop, input int mode, input bit disturb, input string name);
    logic [W-1:0] exp, got;
    int n;
    mode_a = mode;
    exp_q.push_back(model_a(stop, mode));
    @(negedge clk);
    bus_a.start = 1'b1;
    bus_a.stop_on_fail = stop;
    @(posedge clk); #1;
    n = 1;
    bus_a.start = 1'b0;
    bus_a.stop_on_fail = ~stop;
    checks++;
    if (bus_a.busy !== 1'b1 || bus_a.vec_out !== 3'd0) begin
      failures++;
      $display("FAIL %s_start: busy=%b vec=%0d, required busy=1 vec=0", name, bus_a.busy, bus_a.vec_out);
    end
    while (bus_a.done !== 1'b1 && n < BUDGET) begin
      bus_a.start = (disturb && (n == 4 || n == 9)) ? 1'b1 : 1'b0;
      @(posedge clk); #1;
      n++;
    end
    bus_a.start = 1'b0;
    got = {8'(n), bus_a.pass, {1'b0, bus_a.err_count}, {1'b0, bus_a.first_fail}, bus_a.first_fail_valid};
    exp = exp_q.pop_front();
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s_result: got cyc=%0d pass=%b err=%0d ff=%0d ffv=%b, required cyc=%0d pass=%b err=%0d ff=%0d ffv=%b",
               name, got[18:11], got[10], got[9:5], got[4:1], got[0],
               exp[18:11], exp[10], exp[9:5], exp[4:1], exp[0]);
    end
    checks++;
    if (bus_a.busy !== 1'b0) begin
      failures++;
      $display("FAIL %s_busy_at_done: busy=%b, required 0", name, bus_a.busy);
    end
    @(posedge clk); #1;
    checks++;
    if (bus_a.done !== 1'b0 || bus_a.pass !== exp[10] || bus_a.err_count !== exp[8:5]) begin
      failures++;
      $display("FAIL %s_hold: done=%b pass=%b err=%0d, required done=0 pass=%b err=%0d",
               name, bus_a.done, bus_a.pass, bus_a.err_count, exp[10], exp[8:5]);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1;
    bus_a.start = 1'b0; bus_a.stop_on_fail = 1'b0;
    bus_b.start = 1'b0; bus_b.stop_on_fail = 1'b0; bus_b.y_dut = 1'b1;
    mode_a = 0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({bus_a.vec_out, bus_a.busy, bus_a.done, bus_a.pass, bus_a.err_count, bus_a.first_fail,
         bus_a.first_fail_valid} !== '0 || bus_a.state_dbg !== ST_IDLE) begin
      failures++;
      $display("FAIL reset_a: vec=%0d busy=%b done=%b pass=%b err=%0d ff=%0d ffv=%b, required all 0",
               bus_a.vec_out, bus_a.busy, bus_a.done, bus_a.pass, bus_a.err_count,
               bus_a.first_fail, bus_a.first_fail_valid);
    end
    checks++;
    if ({bus_b.vec_out, bus_b.busy, bus_b.done, bus_b.pass, bus_b.err_count, bus_b.first_fail,
         bus_b.first_fail_valid} !== '0 || bus_b.state_dbg !== ST_IDLE) begin
      failures++;
      $display("FAIL reset_b: vec=%0d busy=%b err=%0d, required all 0", bus_b.vec_out, bus_b.busy, bus_b.err_count);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_all_fail_settle0();
    int n;
    logic [W-1:0] exp, got;
    exp_q.push_back({8'd17, 1'b0, 5'd16, 4'd0, 1'b1});
    @(negedge clk);
    bus_b.start = 1'b1;
    @(posedge clk); #1;
    bus_b.start = 1'b0;
    n = 1;
    while (bus_b.done !== 1'b1 && n < BUDGET) begin
      @(posedge clk); #1;
      n++;
    end
    got = {8'(n), bus_b.pass, bus_b.err_count, bus_b.first_fail, bus_b.first_fail_valid};
    exp = exp_q.pop_front();
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL settle0_all_fail: got cyc=%0d pass=%b err=%0d ff=%0d ffv=%b, required cyc=%0d pass=%b err=%0d ff=%0d ffv=%b",
               got[18:11], got[10], got[9:5], got[4:1], got[0],
               exp[18:11], exp[10], exp[9:5], exp[4:1], exp[0]);
    end
  endtask

  task automatic test_reset_mid_sweep();
    int n;
    bit saw_done;
    mode_a = 0;
    @(negedge clk);
    bus_a.start = 1'b1;
    bus_a.stop_on_fail = 1'b0;
    @(posedge clk); #1;
    bus_a.start = 1'b0;
    n = 0;
    while (bus_a.vec_out !== 3'd3 && n < BUDGET) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (n >= BUDGET) begin
      failures++;
      $display("FAIL midreset_reach_vec3: timeout, vec=%0d required 3", bus_a.vec_out);
    end
    reset = 1'b1;
    #1;
    checks++;
    if ({bus_a.vec_out, bus_a.busy, bus_a.done, bus_a.pass, bus_a.err_count, bus_a.first_fail,
         bus_a.first_fail_valid} !== '0 || bus_a.state_dbg !== ST_IDLE) begin
      failures++;
      $display("FAIL midreset_outputs: vec=%0d busy=%b done=%b err=%0d, required all 0",
               bus_a.vec_out, bus_a.busy, bus_a.done, bus_a.err_count);
    end
    @(negedge clk);
    reset = 1'b0;
    saw_done = 1'b0;
    repeat (25) begin
      @(posedge clk); #1;
      if (bus_a.done === 1'b1 || bus_a.busy === 1'b1) saw_done = 1'b1;
    end
    checks++;
    if (saw_done) begin
      failures++;
      $display("FAIL midreset_no_done: activity after reset=1, required 0");
    end
    run_a(1'b0, 0, 1'b0, "after_reset");
  endtask

  task automatic test_back_to_back();
    int n;
    mode_a = 0;
    @(negedge clk);
    bus_a.start = 1'b1;
    bus_a.stop_on_fail = 1'b0;
    n = 0;
    while (bus_a.done !== 1'b1 && n < BUDGET) begin
      @(posedge clk); #1;
      n++;
    end
    @(posedge clk); #1;
    checks++;
    if (bus_a.busy !== 1'b0 || bus_a.state_dbg !== ST_IDLE) begin
      failures++;
      $display("FAIL b2b_idle_gap: busy=%b state=%0d, required busy=0 state=0", bus_a.busy, bus_a.state_dbg);
    end
    @(posedge clk); #1;
    bus_a.start = 1'b0;
    checks++;
    if (bus_a.busy !== 1'b1 || bus_a.vec_out !== 3'd0 || bus_a.pass !== 1'b0) begin
      failures++;
      $display("FAIL b2b_retrigger: busy=%b vec=%0d pass=%b, required busy=1 vec=0 pass=0",
               bus_a.busy, bus_a.vec_out, bus_a.pass);
    end
    n = 1;
    while (bus_a.done !== 1'b1 && n < BUDGET) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (n != 17 || bus_a.pass !== 1'b1) begin
      failures++;
      $display("FAIL b2b_second_sweep: cyc=%0d pass=%b, required cyc=17 pass=1", n, bus_a.pass);
    end
    @(posedge clk); #1;
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    run_a(1'b0, 0, 1'b0, "pass_sweep");
    run_a(1'b0, 1, 1'b0, "two_fails");
    run_a(1'b1, 2, 1'b0, "stop_on_fail");
    run_a(1'b0, $urandom_range(0, 2), 1'b0, "random_mode");
    test_all_fail_settle0();
    test_reset_mid_sweep();
    run_a(1'b0, 1, 1'b1, "start_while_busy");
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
